// File: rtl/sha256_chain_core.sv
// rtl/sha256_chain_core.sv - multi-block SHA-256 compression engine with chaining state
module sha256_chain_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic [1:0]   in_mode,
  input  logic [255:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  output logic [255:0] out_digest,
  input  logic         out_ready
);

  localparam int NUM_ITER = 64 / ROUNDS_PER_CYCLE;

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
    $error("sha256_chain_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Slide the 16-word schedule window forward by ROUNDS_PER_CYCLE words.
  // Later new words may depend on earlier new words, hence the extended buffer.
  function automatic logic [15:0][31:0] next_window(input logic [15:0][31:0] w);
    logic [31:0]       x [16+ROUNDS_PER_CYCLE];
    logic [15:0][31:0] r;
    for (int j = 0; j < 16; j++) begin
      x[j] = w[j];
    end
    for (int j = 16; j < 16 + ROUNDS_PER_CYCLE; j++) begin
      x[j] = x[j-16] + ssig0(x[j-15]) + x[j-7] + ssig1(x[j-2]);
    end
    for (int j = 0; j < 16; j++) begin
      r[j] = x[j+ROUNDS_PER_CYCLE];
    end
    return r;
  endfunction

  // ROUNDS_PER_CYCLE chained rounds starting at round index t0; w[k] holds W[t0+k].
  function automatic logic [255:0] compress(input logic [255:0]      st,
                                            input logic [5:0]        t0,
                                            input logic [15:0][31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [5:0]  t;
    a = st[255:224]; b = st[223:192]; c = st[191:160]; d = st[159:128];
    e = st[127:96];  f = st[95:64];   g = st[63:32];   h = st[31:0];
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      t  = t0 + 6'(k);
      t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + K_TAB[t] + w[k];
      t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      h  = g;
      g  = f;
      f  = e;
      e  = d + t1;
      d  = c;
      c  = b;
      b  = a;
      a  = t1 + t2;
    end
    return {a, b, c, d, e, f, g, h};
  endfunction

  state_t            state_q;
  logic [5:0]        cnt_q;
  logic              last_q;
  logic [255:0]      base_q;
  logic [255:0]      chain_q;
  logic [255:0]      wv_q;
  logic [15:0][31:0] w_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [255:0]      out_digest_q;

  logic [255:0]      base_d;
  logic [255:0]      wv_d;
  logic [15:0][31:0] w_d;
  logic [15:0][31:0] w_load;
  logic [255:0]      hsum_d;
  logic [5:0]        t_base;

  assign t_base = cnt_q * 6'(ROUNDS_PER_CYCLE);
  assign wv_d   = compress(wv_q, t_base, w_q);
  assign w_d    = next_window(w_q);

  // Starting hash value chosen by the block's mode; the reserved mode behaves like mode 0.
  always_comb begin
    case (in_mode)
      2'd1:    base_d = chain_q;
      2'd2:    base_d = in_state;
      default: base_d = IV;
    endcase
  end

  // Unpack the block so W0 sits at window slot 0.
  always_comb begin
    w_load = '0;
    for (int j = 0; j < 16; j++) begin
      w_load[j] = in_block[511-32*j -: 32];
    end
  end

  // Feed-forward: word-wise sum of the starting hash and the working variables.
  always_comb begin
    hsum_d = '0;
    for (int j = 0; j < 8; j++) begin
      hsum_d[255-32*j -: 32] = base_q[255-32*j -: 32] + wv_q[255-32*j -: 32];
    end
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      base_q       <= IV;
      chain_q      <= IV;
      wv_q         <= IV;
      w_q          <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_digest_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_ready_q && in_valid) begin
            base_q     <= base_d;
            wv_q       <= base_d;
            w_q        <= w_load;
            last_q     <= in_last;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_ROUND;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_ROUND: begin
          wv_q <= wv_d;
          w_q  <= w_d;
          if (cnt_q == 6'(NUM_ITER - 1)) begin
            state_q <= ST_FINAL;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        ST_FINAL: begin
          chain_q <= hsum_d;
          if (last_q) begin
            out_digest_q <= hsum_d;
            out_valid_q  <= 1'b1;
            state_q      <= ST_OUT;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_digest = out_digest_q;

endmodule
